// File: rtl/relu_maxpool1_if.sv
// Stream bundle between the conv1 result stream and the ReLU + 2x2 max-pool stage.
// The master side drives samples and clear; the slave side returns pooled tiles.
interface relu_maxpool1_if #(
  parameter int DATA_W = 22
) ();
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              frame_done;

  modport master (
    output clear, in_valid, in_data,
    input  out_valid, out_data, out_last, frame_done
  );

  modport slave (
    input  clear, in_valid, in_data,
    output out_valid, out_data, out_last, frame_done
  );
endinterface

// File: rtl/relu_maxpool1.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-ordered conv1 stream.
// Only one row of horizontal pair maxima is stored; the row buffer is read one
// sample early (on the even column of an odd row) so it maps onto block RAM
// with a registered read port.
module relu_maxpool1 #(
  parameter int DATA_W = 22,
  parameter int IN_W   = 24,
  parameter int IN_H   = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  relu_maxpool1_if.slave bus
);

  localparam int HALF_W = IN_W / 2;
  localparam int COL_W  = (IN_W > 2) ? $clog2(IN_W) : 1;
  localparam int ROW_W  = (IN_H > 2) ? $clog2(IN_H) : 1;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  // Odd or tiny feature maps cannot be tiled 2x2 without leftovers.
  generate
    if ((IN_W < 2) || ((IN_W % 2) != 0)) begin : g_bad_w
      $error("relu_maxpool1: IN_W must be even and >= 2");
    end
    if ((IN_H < 2) || ((IN_H % 2) != 0)) begin : g_bad_h
      $error("relu_maxpool1: IN_H must be even and >= 2");
    end
  endgenerate

  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [DATA_W-1:0] pair_reg;
  logic [DATA_W-1:0] rd_reg;
  logic [DATA_W-1:0] rowbuf [0:HALF_W-1];

  logic              accept;
  logic              col_odd;
  logic              row_odd;
  logic              col_end;
  logic              row_end;
  logic              emit;
  logic [IDX_W-1:0]  buf_idx;
  logic [DATA_W-1:0] relu_val;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] tile_max;

  // Sample qualification, ReLU and the running maxima (all compares unsigned on
  // nonnegative values, so no overflow is possible).
  always_comb begin
    accept   = bus.in_valid && !bus.clear;
    relu_val = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
    col_odd  = col_reg[0];
    row_odd  = row_reg[0];
    col_end  = (col_reg == COL_W'(IN_W - 1));
    row_end  = (row_reg == ROW_W'(IN_H - 1));
    emit     = accept && col_odd && row_odd;
    buf_idx  = IDX_W'(col_reg >> 1);
    pair_max = (relu_val > pair_reg) ? relu_val : pair_reg;
    tile_max = (rd_reg > pair_max) ? rd_reg : pair_max;
  end

  // Raster position counters and the left-column pair register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg  <= '0;
      row_reg  <= '0;
      pair_reg <= '0;
    end else if (bus.clear) begin
      col_reg  <= '0;
      row_reg  <= '0;
      pair_reg <= '0;
    end else if (accept) begin
      if (!col_odd) begin
        pair_reg <= relu_val;
      end
      if (col_end) begin
        col_reg <= '0;
        row_reg <= row_end ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Row buffer write: top-row pair maxima, stored on odd columns of even rows.
  always_ff @(posedge clk) begin
    if (accept && col_odd && !row_odd) begin
      rowbuf[buf_idx] <= pair_max;
    end
  end

  // Row buffer registered read, fetched on the even column so it is ready for
  // the odd column that completes the tile.
  always_ff @(posedge clk) begin
    if (accept && !col_odd && row_odd) begin
      rd_reg <= rowbuf[buf_idx];
    end
  end

  // Pooled output beat, last-tile flag and the trailing frame_done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_last   <= 1'b0;
      bus.frame_done <= 1'b0;
    end else if (bus.clear) begin
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= emit;
      bus.out_last   <= emit && col_end && row_end;
      bus.frame_done <= bus.out_last;
      if (emit) begin
        bus.out_data <= tile_max;
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool1.sv
// Bench for relu_maxpool1: frames of conv1 samples are driven with optional
// random gaps and the pooled beats are compared to a tile-level reference.
module tb_relu_maxpool1;
  localparam int DW = 22;
  localparam int W  = 24;
  localparam int H  = 24;
  localparam int NT = (W / 2) * (H / 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  relu_maxpool1_if #(.DATA_W(DW)) bus ();

  relu_maxpool1 #(.DATA_W(DW), .IN_W(W), .IN_H(H)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] obs_data[$];
  bit            obs_last[$];
  int            obs_cyc[$];
  int            fd_cyc[$];
  logic [DW-1:0] exp_data[$];
  bit            exp_last[$];
  int            stim[H][W];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output beat and frame_done pulse away from the clock edge.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      obs_data.push_back(bus.out_data);
      obs_last.push_back(bus.out_last);
      obs_cyc.push_back(cyc);
    end
    if (bus.frame_done === 1'b1) fd_cyc.push_back(cyc);
  end

  task automatic clear_queues();
    obs_data.delete(); obs_last.delete(); obs_cyc.delete(); fd_cyc.delete();
    exp_data.delete(); exp_last.delete();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_sample(input int v);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(v);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_frame(input int gap_pct);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        while ($urandom_range(0, 99) < gap_pct) idle(1);
        drive_sample(stim[r][c]);
      end
  endtask

  // Reference: each tile's output is the max of zero and its four samples.
  function automatic void model_frame();
    for (int ti = 0; ti < H / 2; ti++)
      for (int tj = 0; tj < W / 2; tj++) begin
        int m = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (stim[2*ti+dr][2*tj+dc] > m) m = stim[2*ti+dr][2*tj+dc];
        exp_data.push_back(DW'(m));
        exp_last.push_back((ti == H/2-1) && (tj == W/2-1));
      end
  endfunction

  function automatic void fill_ramp();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) stim[r][c] = r * W + c;
  endfunction

  function automatic void fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int u = int'($urandom_range(0, 4194303));
        stim[r][c] = u - 2097152;
      end
  endfunction

  task automatic test_reset();
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.frame_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%0b data=%0d last=%0b fd=%0b exp all 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.frame_done);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_queues();
    idle(10);
    checks++;
    if (obs_data.size() != 0 || fd_cyc.size() != 0) begin
      failures++;
      $display("FAIL reset_idle got beats=%0d fd=%0d exp 0/0", obs_data.size(), fd_cyc.size());
    end
    $display("test_reset done");
  endtask

  // Shared body shape repeated per scenario: beat count, beat values and flags,
  // frame_done timing relative to the last beat, and frame_done count.
  task automatic test_ramp();
    int nl = 0; int nexp = 0;
    clear_queues(); fill_ramp(); model_frame(); drive_frame(0); idle(4);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      failures++; $display("FAIL ramp_count got=%0d exp=%0d", obs_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
        failures++;
        $display("FAIL ramp_beat%0d got=%0d/%0b exp=%0d/%0b", k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
      end
    end
    if (obs_data.size() == NT) begin
      checks++;
      if (obs_data[0] !== DW'(25) || obs_data[NT-1] !== DW'(575)) begin
        failures++; $display("FAIL ramp_ends got=%0d,%0d exp=25,575", obs_data[0], obs_data[NT-1]);
      end
    end
    foreach (exp_last[k]) if (exp_last[k]) nexp++;
    for (int k = 0; k < obs_data.size(); k++)
      if (obs_last[k]) begin
        checks++;
        if (nl >= fd_cyc.size() || fd_cyc[nl] != obs_cyc[k] + 1) begin
          failures++; $display("FAIL ramp_frame_done last_cyc=%0d fd_seen=%0d", obs_cyc[k], fd_cyc.size());
        end
        nl++;
      end
    checks++;
    if (fd_cyc.size() != nexp) begin
      failures++; $display("FAIL ramp_fd_count got=%0d exp=%0d", fd_cyc.size(), nexp);
    end
    $display("test_ramp beats=%0d", obs_data.size());
  endtask

  task automatic test_negative();
    clear_queues();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) stim[r][c] = -5;
    model_frame(); drive_frame(0); idle(4);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      failures++; $display("FAIL neg_count got=%0d exp=%0d", obs_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
        failures++;
        $display("FAIL neg_beat%0d got=%0d/%0b exp=%0d/%0b", k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
      end
    end
    $display("test_negative beats=%0d", obs_data.size());
  endtask

  task automatic test_single_tile();
    clear_queues();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) stim[r][c] = -3;
    for (int ti = 0; ti < H / 2; ti++)
      for (int tj = 0; tj < W / 2; tj++) begin
        int pos = (ti * (W / 2) + tj + int'($urandom_range(0, 3))) % 4;
        stim[2*ti + pos/2][2*tj + pos%2] = 1000;
      end
    model_frame(); drive_frame(20); idle(4);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      failures++; $display("FAIL tile_count got=%0d exp=%0d", obs_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
        failures++;
        $display("FAIL tile_beat%0d got=%0d/%0b exp=%0d/%0b", k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
      end
    end
    $display("test_single_tile beats=%0d", obs_data.size());
  endtask

  task automatic test_random_gaps(input bit ramp);
    int nl = 0;
    clear_queues();
    if (ramp) fill_ramp(); else fill_random();
    model_frame(); drive_frame(50); idle(4);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      failures++; $display("FAIL gaps_count got=%0d exp=%0d", obs_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
        failures++;
        $display("FAIL gaps_beat%0d got=%0d/%0b exp=%0d/%0b", k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
      end
    end
    for (int k = 0; k < obs_data.size(); k++)
      if (obs_last[k]) begin
        checks++;
        if (nl >= fd_cyc.size() || fd_cyc[nl] != obs_cyc[k] + 1) begin
          failures++; $display("FAIL gaps_frame_done last_cyc=%0d fd_seen=%0d", obs_cyc[k], fd_cyc.size());
        end
        nl++;
      end
    $display("test_random_gaps ramp=%0b beats=%0d", ramp, obs_data.size());
  endtask

  task automatic test_clear();
    fill_ramp();
    for (int r = 0; r < 5; r++) for (int c = 0; c < W; c++) drive_sample(stim[r][c]);
    for (int c = 0; c < 11; c++) drive_sample(stim[5][c]);
    idle(3);
    clear_queues();
    // The dropped sample would complete a tile if it were accepted.
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = DW'(stim[5][11]);
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    model_frame(); drive_frame(0); idle(4);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      failures++; $display("FAIL clear_count got=%0d exp=%0d", obs_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
        failures++;
        $display("FAIL clear_beat%0d got=%0d/%0b exp=%0d/%0b", k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
      end
    end
    $display("test_clear beats=%0d", obs_data.size());
  endtask

  task automatic test_back_to_back();
    int nl = 0; int nexp = 0;
    clear_queues();
    fill_random(); model_frame(); drive_frame(0);
    fill_random(); model_frame(); drive_frame(0);
    idle(4);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", obs_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
        failures++;
        $display("FAIL b2b_beat%0d got=%0d/%0b exp=%0d/%0b", k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
      end
    end
    foreach (exp_last[k]) if (exp_last[k]) nexp++;
    for (int k = 0; k < obs_data.size(); k++)
      if (obs_last[k]) begin
        checks++;
        if (nl >= fd_cyc.size() || fd_cyc[nl] != obs_cyc[k] + 1) begin
          failures++; $display("FAIL b2b_frame_done last_cyc=%0d fd_seen=%0d", obs_cyc[k], fd_cyc.size());
        end
        nl++;
      end
    checks++;
    if (fd_cyc.size() != nexp) begin
      failures++; $display("FAIL b2b_fd_count got=%0d exp=%0d", fd_cyc.size(), nexp);
    end
    $display("test_back_to_back beats=%0d lasts=%0d", obs_data.size(), nl);
  endtask

  task automatic test_async_reset();
    fill_random();
    for (int r = 0; r < 7; r++) for (int c = 0; c < W; c++) drive_sample(stim[r][c]);
    for (int c = 0; c < 9; c++) drive_sample(stim[7][c]);
    // Assert reset between edges while a sample is still being presented.
    bus.in_valid = 1'b1; bus.in_data = DW'(stim[7][9]);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_last, bus.frame_done} !== '0) begin
      failures++;
      $display("FAIL arst_outputs got valid=%0b data=%0d last=%0b fd=%0b exp all 0",
               bus.out_valid, bus.out_data, bus.out_last, bus.frame_done);
    end
    bus.in_valid = 1'b0;
    clear_queues();
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random(); model_frame(); drive_frame(10); idle(4);
    checks++;
    if (obs_data.size() != exp_data.size()) begin
      failures++; $display("FAIL arst_count got=%0d exp=%0d", obs_data.size(), exp_data.size());
    end
    for (int k = 0; k < exp_data.size() && k < obs_data.size(); k++) begin
      checks++;
      if (obs_data[k] !== exp_data[k] || obs_last[k] !== exp_last[k]) begin
        failures++;
        $display("FAIL arst_beat%0d got=%0d/%0b exp=%0d/%0b", k, obs_data[k], obs_last[k], exp_data[k], exp_last[k]);
      end
    end
    $display("test_async_reset beats=%0d", obs_data.size());
  endtask

  initial begin
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    test_reset();
    test_ramp();
    test_negative();
    test_single_tile();
    test_random_gaps(1'b1);
    test_random_gaps(1'b0);
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
